// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - opcode / funct constants for the supported instruction subset
//   - ALU operation codes driven on alu_op
//   - FSM state enum, trap cause encoding
//   - ctrlOutT: every datapath control signal in one bundle
package mips_ctrl_pkg;

  localparam int ALU_CODE_W = 4;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type functs (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADDU = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SUBU = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_SLT  = 4'd7
  } aluCodeT;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB,
    ST_MEM_ADDR, ST_MEM_RD, ST_LOAD_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_TRAP
  } ctrlStateT;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } errCauseT;

  typedef struct packed {
    logic                  memReq;
    logic                  memWe;
    logic                  iOrD;
    logic                  irWrite;
    logic                  pcWrite;
    logic [1:0]            pcSrc;
    logic                  aluSrcA;
    logic [1:0]            aluSrcB;
    logic [ALU_CODE_W-1:0] aluOp;
    logic                  regDst;
    logic                  memToReg;
    logic                  regWrite;
    logic                  instrDone;
  } ctrlOutT;

  // States that hold a memory request open.
  function automatic logic isMemState(ctrlStateT s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder.
//   funct : instr[5:0]
//   aluOp : ALU operation for the funct (ALU_NOP when illegal)
//   legal : funct is one of the supported R-type operations
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]            funct,
  output logic [ALU_CODE_W-1:0] aluOp,
  output logic                  legal
);

  always_comb begin
    aluOp = ALU_NOP;
    legal = 1'b1;
    case (funct)
      FN_ADD:  aluOp = ALU_ADD;
      FN_ADDU: aluOp = ALU_ADDU;
      FN_SUB:  aluOp = ALU_SUB;
      FN_SUBU: aluOp = ALU_SUBU;
      FN_AND:  aluOp = ALU_AND;
      FN_OR:   aluOp = ALU_OR;
      FN_SLT:  aluOp = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback and drives all datapath selects and write enables.
//   clk, rst_n      : clock, async active-low reset (forces RESET, clears counters)
//   instr           : IR contents, stable from DECODE onward
//   alu_zero        : ALU zero flag, used only in BRANCH
//   mem_ready       : memory completes the current request this cycle
//   mem_req/mem_we/i_or_d, ir_write, pc_write/pc_src,
//   alu_src_a/alu_src_b/alu_op, reg_dst/mem_to_reg/reg_write : datapath controls
//   instr_done      : one-cycle pulse when an instruction retires
//   instr_count     : retired-instruction count (wraps)
//   err_cause       : trap cause, nonzero only while in TRAP
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 0,
  parameter int HALT_ON_TRAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count,
  output logic [1:0]         err_cause
);

  // The wait counter only ever needs to hold MEM_TIMEOUT-1: the access either
  // completes or traps on the wait cycle that would take it to MEM_TIMEOUT.
  localparam int WAIT_W = (MEM_TIMEOUT <= 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  ctrlStateT stateQ, stateD;
  errCauseT  errQ, errD;
  ctrlOutT   ctrl;

  logic [WAIT_W-1:0]     waitCnt;
  logic [CNT_W-1:0]      cntQ;
  logic [5:0]            opcode, funct;
  logic [ALU_CODE_W-1:0] fnAluOp;
  logic                  fnLegal;
  logic                  memWait, timeout;
  logic                  unusedBits;

  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign unusedBits = ^instr[25:6];

  mips_alu_decode uAluDec (
    .funct (funct),
    .aluOp (fnAluOp),
    .legal (fnLegal)
  );

  // A completing mem_ready always wins over the timeout on the same cycle,
  // since memWait is false whenever mem_ready is high.
  assign memWait = isMemState(stateQ) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && memWait && (waitCnt == WAIT_LAST);

  // State, trap cause and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= ST_RESET;
      errQ    <= ERR_NONE;
      waitCnt <= '0;
      cntQ    <= '0;
    end else begin
      stateQ <= stateD;
      errQ   <= errD;
      // Every entry into a memory state is a state change, so clearing on
      // any change gives each access a fresh wait budget.
      if (stateD != stateQ)
        waitCnt <= '0;
      else if (memWait)
        waitCnt <= waitCnt + 1'b1;
      if (ctrl.instrDone)
        cntQ <= cntQ + 1'b1;
    end
  end

  // Next state
  always_comb begin
    stateD = stateQ;
    errD   = errQ;
    case (stateQ)
      ST_RESET:  stateD = ST_FETCH;
      ST_FETCH:  if (mem_ready) stateD = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:         stateD = fnLegal ? ST_EXEC_R : ST_TRAP;
          OP_ADDI, OP_ADDIU: stateD = ST_EXEC_I;
          OP_LW, OP_SW:     stateD = ST_MEM_ADDR;
          OP_BEQ:           stateD = ST_BRANCH;
          OP_J:             stateD = ST_JUMP;
          default:          stateD = ST_TRAP;
        endcase
        if (stateD == ST_TRAP) errD = ERR_ILLEGAL;
      end
      ST_EXEC_R:   stateD = ST_R_WB;
      ST_R_WB:     stateD = ST_FETCH;
      ST_EXEC_I:   stateD = ST_I_WB;
      ST_I_WB:     stateD = ST_FETCH;
      ST_MEM_ADDR: stateD = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) stateD = ST_LOAD_WB;
      ST_LOAD_WB:  stateD = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) stateD = ST_FETCH;
      ST_BRANCH:   stateD = ST_FETCH;
      ST_JUMP:     stateD = ST_FETCH;
      ST_TRAP:     if (HALT_ON_TRAP == 0) stateD = ST_FETCH;
      default:     stateD = ST_RESET;
    endcase
    if (timeout) begin
      stateD = ST_TRAP;
      errD   = ERR_TIMEOUT;
    end
  end

  // Outputs, decoded from state plus live inputs
  always_comb begin
    ctrl = '0;
    case (stateQ)
      ST_FETCH: begin
        ctrl.memReq  = 1'b1;
        ctrl.aluSrcB = 2'd1;
        ctrl.aluOp   = ALU_ADDU;
        ctrl.irWrite = mem_ready;
        ctrl.pcWrite = mem_ready;
      end
      ST_DECODE: begin
        ctrl.aluSrcB = 2'd3;
        ctrl.aluOp   = ALU_ADDU;
      end
      ST_EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = fnAluOp;
      end
      ST_R_WB: begin
        ctrl.regDst    = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'd2;
        ctrl.aluOp   = (opcode == OP_ADDI) ? ALU_ADD : ALU_ADDU;
      end
      ST_I_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'd2;
        ctrl.aluOp   = ALU_ADDU;
      end
      ST_MEM_RD: begin
        ctrl.memReq = 1'b1;
        ctrl.iOrD   = 1'b1;
      end
      ST_LOAD_WB: begin
        ctrl.memToReg  = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.memReq    = 1'b1;
        ctrl.memWe     = 1'b1;
        ctrl.iOrD      = 1'b1;
        ctrl.instrDone = mem_ready;
      end
      ST_BRANCH: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluOp     = ALU_SUBU;
        ctrl.pcSrc     = 2'd1;
        ctrl.pcWrite   = alu_zero;
        ctrl.instrDone = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSrc     = 2'd2;
        ctrl.instrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req     = ctrl.memReq;
  assign mem_we      = ctrl.memWe;
  assign i_or_d      = ctrl.iOrD;
  assign ir_write    = ctrl.irWrite;
  assign pc_write    = ctrl.pcWrite;
  assign pc_src      = ctrl.pcSrc;
  assign alu_src_a   = ctrl.aluSrcA;
  assign alu_src_b   = ctrl.aluSrcB;
  assign alu_op      = ALUOP_W'(ctrl.aluOp);
  assign reg_dst     = ctrl.regDst;
  assign mem_to_reg  = ctrl.memToReg;
  assign reg_write   = ctrl.regWrite;
  assign instr_done  = ctrl.instrDone;
  assign instr_count = cntQ;
  assign err_cause   = (stateQ == ST_TRAP) ? errQ : ERR_NONE;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Instance A: MEM_TIMEOUT=8, halting trap.
// Instance B shares A's inputs: no timeout, one-cycle trap, 4-bit counter.
module tb_multicycle_control;

  localparam int TO = 8;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       instrDone;
    logic [1:0] errCause;
  } outT;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    bit          az;
    int          cycles;
    outT         exec3;
  } vecT;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;

  logic aMemReq, aMemWe, aIOrD, aIrW, aPcW, aSrcA, aRegDst, aM2R, aRegW, aDone;
  logic [1:0] aPcSrc, aSrcB, aErr;
  logic [3:0] aAluOp;
  logic [31:0] aCnt;
  logic bMemReq, bMemWe, bIOrD, bIrW, bPcW, bSrcA, bRegDst, bM2R, bRegW, bDone;
  logic [1:0] bPcSrc, bSrcB, bErr;
  logic [3:0] bAluOp;
  logic [3:0] bCnt;

  outT actA, actB;
  assign actA = {aMemReq, aMemWe, aIOrD, aIrW, aPcW, aPcSrc, aSrcA, aSrcB, aAluOp,
                 aRegDst, aM2R, aRegW, aDone, aErr};
  assign actB = {bMemReq, bMemWe, bIOrD, bIrW, bPcW, bPcSrc, bSrcB[1] & 1'b0 | bSrcA, bSrcB, bAluOp,
                 bRegDst, bM2R, bRegW, bDone, bErr};

  multicycle_control #(.ALUOP_W(4), .CNT_W(32), .MEM_TIMEOUT(TO), .HALT_ON_TRAP(1)) dutA (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(aMemReq), .mem_we(aMemWe), .i_or_d(aIOrD), .ir_write(aIrW), .pc_write(aPcW),
    .pc_src(aPcSrc), .alu_src_a(aSrcA), .alu_src_b(aSrcB), .alu_op(aAluOp), .reg_dst(aRegDst),
    .mem_to_reg(aM2R), .reg_write(aRegW), .instr_done(aDone), .instr_count(aCnt), .err_cause(aErr));

  multicycle_control #(.ALUOP_W(4), .CNT_W(4), .MEM_TIMEOUT(0), .HALT_ON_TRAP(0)) dutB (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(bMemReq), .mem_we(bMemWe), .i_or_d(bIOrD), .ir_write(bIrW), .pc_write(bPcW),
    .pc_src(bPcSrc), .alu_src_a(bSrcA), .alu_src_b(bSrcB), .alu_op(bAluOp), .reg_dst(bRegDst),
    .mem_to_reg(bM2R), .reg_write(bRegW), .instr_done(bDone), .instr_count(bCnt), .err_cause(bErr));

  always #5 clk = ~clk;

  int cmpCnt = 0, errCnt = 0;
  int modelCnt = 0;
  vecT tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmpCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic outT exOut(int a, int b, int op, int ps, int pw, int dn);
    outT o = '0;
    o.aluSrcA = 1'(a); o.aluSrcB = 2'(b); o.aluOp = 4'(op);
    o.pcSrc = 2'(ps); o.pcWrite = 1'(pw); o.instrDone = 1'(dn);
    return o;
  endfunction

  function automatic outT fetchVec(bit rdy);
    outT o = '0;
    o.memReq = 1'b1; o.aluSrcB = 2'd1; o.aluOp = 4'd2;
    o.irWrite = rdy; o.pcWrite = rdy;
    return o;
  endfunction

  function automatic outT trapVec(int cause);
    outT o = '0;
    o.errCause = 2'(cause);
    return o;
  endfunction

  // ALU code for an R-type funct; 0 means not a legal funct.
  function automatic int refAlu(logic [5:0] fn);
    case (fn)
      6'h20: return 1;  6'h21: return 2;  6'h22: return 3;  6'h23: return 4;
      6'h24: return 5;  6'h25: return 6;  6'h2A: return 7;
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive at negedge, sample 2ns later, then retire into the model.
  task automatic step(input logic [31:0] ins, input outT e, input bit mr, input bit az,
                      input string nm);
    @(negedge clk);
    instr = ins; mem_ready = mr; alu_zero = az;
    #2;
    check({nm, " outA"}, 32'(actA), 32'(e));
    check({nm, " cntA"}, aCnt, 32'(modelCnt));
    check({nm, " cntB"}, 32'(bCnt), 32'(modelCnt % 16));
    if (e.errCause == 2'd0) check({nm, " outB"}, 32'(actB), 32'(e));
    if (e.instrDone) modelCnt++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("reset outA", 32'(actA), 32'd0);
    check("reset cntA", aCnt, 32'd0);
    check("reset cntB", 32'(bCnt), 32'd0);
    modelCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("release outA", 32'(actA), 32'd0);
  endtask

  task automatic trapTail(input logic [31:0] ins, input int cause, input int n);
    for (int i = 0; i < n; i++) step(ins, trapVec(cause), 1'b0, rb(), "trap hold");
    doReset();
  endtask

  // A memory access of 'waits' not-ready cycles; times out at TO wait cycles.
  task automatic memPhase(input logic [31:0] ins, input outT ew, input outT ed, input int waits,
                          input string nm, output bit tr);
    int n;
    n = (waits >= TO) ? TO : waits;
    tr = 1'b0;
    for (int i = 0; i < n; i++) step(ins, ew, 1'b0, rb(), {nm, " wait"});
    if (waits >= TO) tr = 1'b1;
    else step(ins, ed, 1'b1, rb(), {nm, " ready"});
  endtask

  // Expected cycle sequence of one instruction, built from its phase list.
  task automatic runInstr(input logic [31:0] ins, input int fw, input int mw, input bit az);
    outT e, ed;
    bit tr;
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    memPhase(ins, fetchVec(1'b0), fetchVec(1'b1), fw, "fetch", tr);
    if (tr) begin trapTail(ins, 2, 3); return; end
    step(ins, exOut(0, 3, 2, 0, 0, 0), rb(), rb(), "decode");
    case (op)
      6'h00: begin
        if (refAlu(fn) != 0) begin
          step(ins, exOut(1, 0, refAlu(fn), 0, 0, 0), rb(), rb(), "exec_r");
          e = '0; e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
          step(ins, e, rb(), rb(), "r_wb");
        end else trapTail(ins, 1, 3);
      end
      6'h08, 6'h09: begin
        step(ins, exOut(1, 2, (op == 6'h08) ? 1 : 2, 0, 0, 0), rb(), rb(), "exec_i");
        e = '0; e.regWrite = 1'b1; e.instrDone = 1'b1;
        step(ins, e, rb(), rb(), "i_wb");
      end
      6'h23: begin
        step(ins, exOut(1, 2, 2, 0, 0, 0), rb(), rb(), "lw addr");
        e = '0; e.memReq = 1'b1; e.iOrD = 1'b1;
        memPhase(ins, e, e, mw, "mem_rd", tr);
        if (tr) trapTail(ins, 2, 3);
        else begin
          e = '0; e.memToReg = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
          step(ins, e, rb(), rb(), "load_wb");
        end
      end
      6'h2B: begin
        step(ins, exOut(1, 2, 2, 0, 0, 0), rb(), rb(), "sw addr");
        e = '0; e.memReq = 1'b1; e.memWe = 1'b1; e.iOrD = 1'b1;
        ed = e; ed.instrDone = 1'b1;
        memPhase(ins, e, ed, mw, "mem_wr", tr);
        if (tr) trapTail(ins, 2, 3);
      end
      6'h04: step(ins, exOut(1, 0, 4, 1, az, 1), rb(), az, "branch");
      6'h02: step(ins, exOut(0, 0, 0, 2, 1, 1), rb(), rb(), "jump");
      default: trapTail(ins, 1, 3);
    endcase
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [5:0] fn;
    int k;
    r = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0, 1, 2, 3, 4, 5, 6, 19: begin
        case ($urandom_range(0, 6))
          0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23;
          4: fn = 6'h24; 5: fn = 6'h25; default: fn = 6'h2A;
        endcase
        return {6'h00, r[25:6], fn};
      end
      7: begin
        fn = r[5:0];
        if (refAlu(fn) != 0) fn = 6'h3F;
        return {6'h00, r[25:6], fn};
      end
      8:       return {6'h08, r[25:0]};
      9:       return {6'h09, r[25:0]};
      10, 11:  return {6'h23, r[25:0]};
      12, 13:  return {6'h2B, r[25:0]};
      14, 15:  return {6'h04, r[25:0]};
      16, 17:  return {6'h02, r[25:0]};
      default: return {(r[0] ? 6'h3F : 6'h0F), r[25:0]};
    endcase
  endfunction

  function automatic int randWait();
    if ($urandom_range(0, 15) == 0) return $urandom_range(TO - 1, TO);
    return $urandom_range(0, 2);
  endfunction

  task automatic addVec(input string nm, input logic [31:0] ins, input bit az, input int cyc,
                        input outT e);
    vecT v;
    v.nm = nm; v.ins = ins; v.az = az; v.cycles = cyc; v.exec3 = e;
    tbl.push_back(v);
  endtask

  initial begin
    outT e;
    // cycle-3 outputs and zero-wait cycle counts per instruction class
    addVec("add",   32'h00221820, 1'b0, 4, exOut(1, 0, 1, 0, 0, 0));
    addVec("addu",  32'h00221821, 1'b0, 4, exOut(1, 0, 2, 0, 0, 0));
    addVec("sub",   32'h00221822, 1'b1, 4, exOut(1, 0, 3, 0, 0, 0));
    addVec("subu",  32'h00221823, 1'b0, 4, exOut(1, 0, 4, 0, 0, 0));
    addVec("and",   32'h00221824, 1'b0, 4, exOut(1, 0, 5, 0, 0, 0));
    addVec("or",    32'h00221825, 1'b1, 4, exOut(1, 0, 6, 0, 0, 0));
    addVec("slt",   32'h0022182A, 1'b0, 4, exOut(1, 0, 7, 0, 0, 0));
    addVec("addi",  32'h20410005, 1'b0, 4, exOut(1, 2, 1, 0, 0, 0));
    addVec("addiu", 32'h2441FFFF, 1'b1, 4, exOut(1, 2, 2, 0, 0, 0));
    addVec("lw",    32'h8C220004, 1'b0, 5, exOut(1, 2, 2, 0, 0, 0));
    addVec("sw",    32'hAC220008, 1'b0, 4, exOut(1, 2, 2, 0, 0, 0));
    addVec("beq z1", 32'h10220003, 1'b1, 3, exOut(1, 0, 4, 1, 1, 1));
    addVec("beq z0", 32'h10220003, 1'b0, 3, exOut(1, 0, 4, 1, 0, 1));
    addVec("j",     32'h08000040, 1'b0, 3, exOut(0, 0, 0, 2, 1, 1));

    doReset();

    // addu straight out of reset
    step(32'h00221821, fetchVec(1'b1), 1'b1, 1'b0, "t1 fetch");
    step(32'h00221821, exOut(0, 3, 2, 0, 0, 0), 1'b1, 1'b0, "t1 decode");
    step(32'h00221821, exOut(1, 0, 2, 0, 0, 0), 1'b1, 1'b0, "t1 exec_r");
    e = '0; e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
    step(32'h00221821, e, 1'b1, 1'b0, "t1 r_wb");

    // table: zero-wait memory, observe cycle 3 and the cycle of retirement
    foreach (tbl[i]) begin
      int c;
      bit done;
      c = 0; done = 1'b0;
      while (!done && c < 12) begin
        @(negedge clk);
        instr = tbl[i].ins; mem_ready = 1'b1; alu_zero = tbl[i].az;
        #2;
        c++;
        if (c == 1) check({tbl[i].nm, " count"}, aCnt, 32'(modelCnt));
        if (c == 3) check({tbl[i].nm, " exec"}, 32'(actA), 32'(tbl[i].exec3));
        done = actA.instrDone;
      end
      check({tbl[i].nm, " cycles"}, 32'(c), 32'(tbl[i].cycles));
      modelCnt++;
    end

    // lw with 3 wait cycles in MEM_RD, then beq both ways
    doReset();
    runInstr(32'h8C220004, 0, 3, 1'b0);
    runInstr(32'h10220003, 0, 0, 1'b1);
    runInstr(32'h10220003, 1, 0, 1'b0);

    // illegal opcode: A halts with cause 1, B traps for one cycle then refetches
    step(32'hFC000000, fetchVec(1'b1), 1'b1, 1'b0, "ill fetch");
    step(32'hFC000000, exOut(0, 3, 2, 0, 0, 0), 1'b1, 1'b0, "ill decode");
    @(negedge clk); mem_ready = 1'b0; #2;
    check("ill trapA", 32'(actA), 32'(trapVec(1)));
    check("ill trapB", 32'(actB), 32'(trapVec(1)));
    @(negedge clk); #2;
    check("ill holdA", 32'(actA), 32'(trapVec(1)));
    check("ill refetchB", 32'(actB), 32'(fetchVec(1'b0)));
    for (int i = 0; i < 18; i++) step(32'hFC000000, trapVec(1), 1'b0, rb(), "ill hold");
    doReset();
    runInstr(32'h00221821, 0, 0, 1'b0);

    // fetch timeout: 8 wait cycles then TRAP cause 2 in A; B keeps waiting
    doReset();
    for (int i = 0; i < TO; i++) step(32'h8C220004, fetchVec(1'b0), 1'b0, rb(), "to wait");
    @(negedge clk); mem_ready = 1'b0; #2;
    check("to trapA", 32'(actA), 32'(trapVec(2)));
    check("to waitB", 32'(actB), 32'(fetchVec(1'b0)));
    trapTail(32'h8C220004, 2, 4);
    // ready on the would-be timeout cycle completes normally
    runInstr(32'h00221821, TO - 1, 0, 1'b0);
    runInstr(32'h8C220004, 0, TO - 1, 1'b0);
    runInstr(32'hAC220008, 0, TO, 1'b0);

    // reset in the middle of a stalled store
    runInstr(32'h00221821, 0, 0, 1'b0);
    step(32'hAC220008, fetchVec(1'b1), 1'b1, 1'b0, "mw fetch");
    step(32'hAC220008, exOut(0, 3, 2, 0, 0, 0), 1'b0, 1'b0, "mw decode");
    step(32'hAC220008, exOut(1, 2, 2, 0, 0, 0), 1'b0, 1'b0, "mw addr");
    e = '0; e.memReq = 1'b1; e.memWe = 1'b1; e.iOrD = 1'b1;
    step(32'hAC220008, e, 1'b0, 1'b0, "mw stall");
    doReset();
    runInstr(32'hAC220008, 0, 1, 1'b0);

    // random instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ins;
      ins = randInstr();
      runInstr(ins, randWait(), randWait(), rb());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
